// File: rtl/spi_mult_master.sv
// SPI master for the serial multiplier slave: shifts out {a,b} MSB first,
// waits a fixed number of idle SCLK edges, then shifts the product back in.
module spi_mult_master #(
  parameter int WIDTH     = 4,
  parameter int CLK_DIV   = 10,
  parameter int GAP_EDGES = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  output logic               SCLK,
  output logic               CS,
  output logic               MOSI,
  input  logic               MISO
);

  localparam int LAST_EDGE = 4*WIDTH + GAP_EDGES;
  localparam int DW        = $clog2(CLK_DIV);
  localparam int EW        = $clog2(LAST_EDGE + 1);

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [EW-1:0] E_LAST   = EW'(LAST_EDGE);
  localparam logic [EW-1:0] LAST_OUT = EW'(2*WIDTH);
  localparam logic [EW-1:0] FIRST_IN = EW'(2*WIDTH + GAP_EDGES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT_OUT, GAP, SHIFT_IN} state_t;

  state_t             state;
  logic [DW-1:0]      div;
  logic [EW-1:0]      edge_cnt;
  logic [EW-1:0]      edge_nxt;
  logic [2*WIDTH-1:0] tx;
  logic [2*WIDTH-1:0] rx;

  assign edge_nxt = edge_cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      div          <= '0;
      edge_cnt     <= '0;
      tx           <= '0;
      rx           <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      SCLK         <= 1'b0;
      CS           <= 1'b0;
      MOSI         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx       <= {a, b};
            rx       <= '0;
            div      <= '0;
            edge_cnt <= '0;
            SCLK     <= 1'b1;
            CS       <= 1'b1;
            busy     <= 1'b1;
            MOSI     <= 1'b0;
            state    <= SHIFT_OUT;
          end
        end
        default: begin
          if (div == DIV_MAX) begin
            div <= '0;
            if (SCLK) begin
              SCLK <= 1'b0;
              if (edge_cnt == E_LAST) begin
                CS           <= 1'b0;
                busy         <= 1'b0;
                result       <= rx;
                result_valid <= 1'b1;
                state        <= IDLE;
              end
            end else begin
              SCLK     <= 1'b1;
              edge_cnt <= edge_nxt;
              if (edge_nxt <= LAST_OUT) begin
                MOSI <= tx[2*WIDTH-1];
                tx   <= {tx[2*WIDTH-2:0], 1'b0};
              end else begin
                MOSI <= 1'b0;
              end
              // Sampling keys off the edge index so a zero-length gap still works.
              if (edge_nxt >= FIRST_IN) begin
                rx    <= {rx[2*WIDTH-2:0], MISO};
                state <= SHIFT_IN;
              end else if (edge_nxt > LAST_OUT) begin
                state <= GAP;
              end
            end
          end else begin
            div <= div + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
